axi_read_stream_tap: RTL
========================

AXI_READ_STREAM_TAP -- requirements
Module: axi_read_stream_tap

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 128, AXI and stream data width
- ADDR_WIDTH, 64, AXI address width
- ID_WIDTH, 32, AXI ID and stream tid width
- LEN_WIDTH, 8, arlen width
- USER_WIDTH, 64, AXI user and stream tuser width
- DEST_WIDTH, 32, stream tdest width
- TYPE_WIDTH, 3, record type field width
- STREAM_DEST, 0, constant tdest value
- FIFO_DEPTH, 16, record FIFO entries (power of 2, >=2)
- MAX_OUTSTANDING, 4, maximum open read bursts
- DROP_MODE, 0, 0 = backpressure AXI when FIFO full, 1 = drop records
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; reset is asynchronous and active-high
- reset, in, 1, asynchronous active-high reset
- enable, in, 1, record generation enable
- fs_ar{id,addr,len,size,burst,lock,cache,prot,region,qos,user,valid}, in, per AXI4, upstream AR channel
- fs_arready, out, 1, upstream AR ready
- fs_r{id,data,resp,last,user,valid}, out, per AXI4, upstream R channel
- fs_rready, in, 1, upstream R ready
- rs_ar*, out, mirror of fs_ar*, downstream AR channel; rs_arready, in, 1
- rs_r*, in, mirror of fs_r*, downstream R channel; rs_rready, out, 1
- stream_t{id,dest,data,strb,keep,last,user,valid}, out, ID/DEST/DATA/DATA/8/DATA/8/1/USER+TYPE/1, record stream
- stream_tready, in, 1, stream ready
- outstanding, out, clog2(MAX_OUTSTANDING+1), open burst count
- fifo_level, out, clog2(FIFO_DEPTH+1), FIFO occupancy
- drop_count, out, 16, dropped record count, saturating

Function
REQ-003 AR and R payloads SHALL pass through combinationally, with zero latency; only valid/ready are gated.
REQ-004 The AR gate SHALL be open only when outstanding < MAX_OUTSTANDING, no R handshake occurs in the same cycle, and (DROP_MODE=1, or enable=0, or the FIFO is not full).
- rs_arvalid = fs_arvalid & gate; fs_arready = rs_arready & gate.
REQ-005 The R gate SHALL be open when DROP_MODE=1, or enable=0, or the FIFO is not full.
- rs_rready = fs_rready & gate; fs_rvalid = rs_rvalid & gate.
REQ-006 On an AR handshake with enable=1, an AR record SHALL be pushed:
- type 3'b001; tid = arid
- tdata = zero-extended {burst,size,len,addr}
- tlast = 1; tuser = {type, aruser}
REQ-007 On an R handshake with enable=1, an R record SHALL be pushed:
- type 3'b010; tid = rid; tdata = rdata
- tlast = rlast; tuser = {type, ruser} with rresp in bits [1:0] of the ruser field
REQ-008 outstanding SHALL increment on an AR handshake and decrement on an R handshake with rlast=1; if both occur in the same cycle, it SHALL be unchanged.
REQ-009 The FIFO SHALL present its head with stream_tvalid = not-empty and pop on stream_tvalid & stream_tready.
- tstrb/tkeep SHALL be all ones; tdest SHALL be STREAM_DEST.
REQ-010 Full SHALL be evaluated on the registered count; a push at full SHALL be refused even if a pop occurs in the same cycle.
- A push and pop in the same cycle at non-full SHALL leave fifo_level unchanged.
REQ-011 In DROP_MODE=1, a record arriving at full SHALL be discarded and drop_count SHALL increment, saturating at 16'hFFFF.
REQ-012 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 Parameters SHALL satisfy ADDR_WIDTH+LEN_WIDTH+5 <= DATA_WIDTH; an elaboration-time check SHALL fail otherwise.

Reset
REQ-014 On reset assertion, all of the following SHALL take effect asynchronously:
- FIFO emptied; stream_tvalid=0
- outstanding=0, fifo_level=0, drop_count=0
REQ-015 A reset mid-burst SHALL discard the burst; the downstream interconnect SHALL be reset concurrently.

Structure
REQ-016 Package axi_tap_pkg SHALL hold the record type codes (AR=3'b001, R=3'b010) and the record struct typedef.
REQ-017 Sub-module tap_record_fifo SHALL implement the parametrised single-push/single-pop FIFO.

Verification
REQ-018 Single AR (addr 0x1000, len 3, id 5) then 4 R beats -> 5 records (1 AR + 4 R); tlast on the AR record and the 4th R record; outstanding 1 then 0.
REQ-019 Five ARs with no R and MAX_OUTSTANDING=4 -> 5th fs_arready held 0; it is accepted the cycle after the first rlast handshake.
REQ-020 DROP_MODE=0, stream_tready=0, 20 R beats -> 16 accepted, then rs_rready=0; 17th accepted one cycle after tready rises.
REQ-021 DROP_MODE=1, same stimulus -> all 20 R beats pass; drop_count=4; fifo_level=16.
REQ-022 AR and R valid in the same cycle -> R accepted, AR accepted the next cycle; record order R then AR.
REQ-023 Reset asserted with fifo_level=7 and outstanding=2 -> all counters 0 and stream_tvalid=0 without a clock edge.

Source files
------------

// File: rtl/axi_tap_pkg.sv
// Shared record definitions for the AXI read-channel tap: type codes and the
// per-record tag that travels through the FIFO beside id/data/user.
package axi_tap_pkg;

  localparam logic [2:0] REC_AR = 3'b001;
  localparam logic [2:0] REC_R  = 3'b010;

  typedef struct packed {
    logic [2:0] rtype;
    logic       last;
  } tap_rec_tag_t;

endpackage

// File: rtl/tap_record_fifo.sv
// Single-push/single-pop record FIFO. Full is taken from the registered count,
// so a push at full is refused even when a pop happens in the same cycle.
module tap_record_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("tap_record_fifo: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == LW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_q];
  assign level_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/axi_read_stream_tap.sv
// Transparent AXI4 read-channel tap: AR/R payloads pass straight through while
// every handshake is logged as a record on an AXI-Stream port.
module axi_read_stream_tap
  import axi_tap_pkg::*;
#(
  parameter int          DATA_WIDTH      = 128,
  parameter int          ADDR_WIDTH      = 64,
  parameter int          ID_WIDTH        = 32,
  parameter int          LEN_WIDTH       = 8,
  parameter int          USER_WIDTH      = 64,
  parameter int          DEST_WIDTH      = 32,
  parameter int          TYPE_WIDTH      = 3,
  parameter int unsigned STREAM_DEST     = 0,
  parameter int          FIFO_DEPTH      = 16,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          DROP_MODE       = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [ID_WIDTH-1:0]                  fs_arid,
  input  logic [ADDR_WIDTH-1:0]                fs_araddr,
  input  logic [LEN_WIDTH-1:0]                 fs_arlen,
  input  logic [2:0]                           fs_arsize,
  input  logic [1:0]                           fs_arburst,
  input  logic                                 fs_arlock,
  input  logic [3:0]                           fs_arcache,
  input  logic [2:0]                           fs_arprot,
  input  logic [3:0]                           fs_arregion,
  input  logic [3:0]                           fs_arqos,
  input  logic [USER_WIDTH-1:0]                fs_aruser,
  input  logic                                 fs_arvalid,
  output logic                                 fs_arready,
  output logic [ID_WIDTH-1:0]                  fs_rid,
  output logic [DATA_WIDTH-1:0]                fs_rdata,
  output logic [1:0]                           fs_rresp,
  output logic                                 fs_rlast,
  output logic [USER_WIDTH-1:0]                fs_ruser,
  output logic                                 fs_rvalid,
  input  logic                                 fs_rready,
  output logic [ID_WIDTH-1:0]                  rs_arid,
  output logic [ADDR_WIDTH-1:0]                rs_araddr,
  output logic [LEN_WIDTH-1:0]                 rs_arlen,
  output logic [2:0]                           rs_arsize,
  output logic [1:0]                           rs_arburst,
  output logic                                 rs_arlock,
  output logic [3:0]                           rs_arcache,
  output logic [2:0]                           rs_arprot,
  output logic [3:0]                           rs_arregion,
  output logic [3:0]                           rs_arqos,
  output logic [USER_WIDTH-1:0]                rs_aruser,
  output logic                                 rs_arvalid,
  input  logic                                 rs_arready,
  input  logic [ID_WIDTH-1:0]                  rs_rid,
  input  logic [DATA_WIDTH-1:0]                rs_rdata,
  input  logic [1:0]                           rs_rresp,
  input  logic                                 rs_rlast,
  input  logic [USER_WIDTH-1:0]                rs_ruser,
  input  logic                                 rs_rvalid,
  output logic                                 rs_rready,
  output logic [ID_WIDTH-1:0]                  stream_tid,
  output logic [DEST_WIDTH-1:0]                stream_tdest,
  output logic [DATA_WIDTH-1:0]                stream_tdata,
  output logic [DATA_WIDTH/8-1:0]              stream_tstrb,
  output logic [DATA_WIDTH/8-1:0]              stream_tkeep,
  output logic                                 stream_tlast,
  output logic [USER_WIDTH+TYPE_WIDTH-1:0]     stream_tuser,
  output logic                                 stream_tvalid,
  input  logic                                 stream_tready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
  output logic [15:0]                          drop_count
);

  localparam int   OUT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int   ARF_W = ADDR_WIDTH + LEN_WIDTH + 5;
  localparam int   TAG_W = $bits(tap_rec_tag_t);
  localparam int   REC_W = ID_WIDTH + DATA_WIDTH + USER_WIDTH + TAG_W;
  localparam logic DROP  = (DROP_MODE != 0);

  generate
    if (ARF_W > DATA_WIDTH || USER_WIDTH < 2) begin : g_bad_widths
      $error("axi_read_stream_tap: AR summary does not fit DATA_WIDTH or USER_WIDTH < 2");
    end
  endgenerate

  logic                  fifo_full, fifo_empty, room;
  logic                  r_hs, ar_hs, ar_gate, push, drop;
  logic [OUT_W-1:0]      out_q, out_d;
  logic [15:0]           drop_q, drop_d;
  logic [ID_WIDTH-1:0]   rec_id, hd_id;
  logic [DATA_WIDTH-1:0] rec_data, hd_data;
  logic [USER_WIDTH-1:0] rec_user, hd_user;
  tap_rec_tag_t          rec_tag, hd_tag;
  logic [REC_W-1:0]      head;

  assign rs_arid     = fs_arid;
  assign rs_araddr   = fs_araddr;
  assign rs_arlen    = fs_arlen;
  assign rs_arsize   = fs_arsize;
  assign rs_arburst  = fs_arburst;
  assign rs_arlock   = fs_arlock;
  assign rs_arcache  = fs_arcache;
  assign rs_arprot   = fs_arprot;
  assign rs_arregion = fs_arregion;
  assign rs_arqos    = fs_arqos;
  assign rs_aruser   = fs_aruser;
  assign fs_rid      = rs_rid;
  assign fs_rdata    = rs_rdata;
  assign fs_rresp    = rs_rresp;
  assign fs_rlast    = rs_rlast;
  assign fs_ruser    = rs_ruser;

  // An R beat always wins the single push slot; AR waits one cycle.
  assign room       = DROP | ~enable | ~fifo_full;
  assign r_hs       = rs_rvalid & fs_rready & room;
  assign ar_gate    = (out_q < OUT_W'(MAX_OUTSTANDING)) & ~r_hs & room;
  assign ar_hs      = fs_arvalid & rs_arready & ar_gate;
  assign rs_arvalid = fs_arvalid & ar_gate;
  assign fs_arready = rs_arready & ar_gate;
  assign rs_rready  = fs_rready & room;
  assign fs_rvalid  = rs_rvalid & room;

  assign push = enable & (ar_hs | r_hs);
  assign drop = DROP & push & fifo_full;

  always_comb begin
    rec_tag.rtype         = REC_AR;
    rec_tag.last          = 1'b1;
    rec_id                = fs_arid;
    rec_data              = '0;
    rec_data[ARF_W-1:0]   = {fs_arburst, fs_arsize, fs_arlen, fs_araddr};
    rec_user              = fs_aruser;
    if (r_hs) begin
      rec_tag.rtype = REC_R;
      rec_tag.last  = rs_rlast;
      rec_id        = rs_rid;
      rec_data      = rs_rdata;
      rec_user      = {rs_ruser[USER_WIDTH-1:2], rs_rresp};
    end
  end

  always_comb begin
    out_d = out_q;
    if (ar_hs && !(r_hs && rs_rlast))
      out_d = out_q + OUT_W'(1);
    else if (!ar_hs && r_hs && rs_rlast && out_q != '0)
      out_d = out_q - OUT_W'(1);
  end

  always_comb begin
    drop_d = drop_q;
    if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  tap_record_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({rec_id, rec_data, rec_user, rec_tag}),
    .pop_i       (stream_tready),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  assign {hd_id, hd_data, hd_user, hd_tag} = head;

  assign stream_tvalid = ~fifo_empty;
  assign stream_tid    = hd_id;
  assign stream_tdest  = DEST_WIDTH'(STREAM_DEST);
  assign stream_tdata  = hd_data;
  assign stream_tstrb  = '1;
  assign stream_tkeep  = '1;
  assign stream_tlast  = hd_tag.last;
  assign stream_tuser  = {TYPE_WIDTH'(hd_tag.rtype), hd_user};
  assign outstanding   = out_q;
  assign drop_count    = drop_q;

endmodule
